// File: rtl/filter_arbiter.sv
// filter_arbiter: round-robin arbiter feeding a shared fixed-latency filter.
// A tag pipeline runs alongside the filter and routes each result back to
// the requester that supplied the sample.
module filter_arbiter #(
  parameter int N   = 4,
  parameter int W   = 16,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  input  logic [N-1:0]   req_parity,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   f_x_data,
  output logic           f_x_valid,
  output logic           f_x_parity,
  input  logic [W-1:0]   f_y_data,
  input  logic           f_y_valid,
  input  logic           f_y_parity,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_parity,
  output logic           busy,
  output logic           err
);

  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int SW  = IW + 1;       // one tag stage: {valid, tag}
  localparam int TPW = LAT * SW;

  logic [W-1:0]  data_arr [N];
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_idx, cand;
  logic          win_found;
  logic          grant;

  logic          f_x_valid_q, f_x_parity_q;
  logic [W-1:0]  f_x_data_q;
  logic [IW-1:0] tag_x_q;

  logic [TPW-1:0] tp_q, tp_d;
  logic [LAT-1:0] stage_v;
  logic           tail_v;
  logic [IW-1:0]  tail_tag;

  logic [N-1:0]  rsp_valid_q;
  logic [W-1:0]  rsp_data_q;
  logic          rsp_parity_q;
  logic          err_q;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*W +: W];
  end

  // Round-robin search: first valid requester after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'((int'(ptr_q) + off) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The winner is always valid, so an offered grant is a completed handshake.
  assign grant     = win_found & enable & ~reset;
  assign req_ready = grant ? (N'(1) << win_idx) : '0;
  assign ptr_d     = grant ? win_idx : ptr_q;

  // Pointer update and filter input register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= IW'(N - 1);
      f_x_valid_q  <= 1'b0;
      f_x_data_q   <= '0;
      f_x_parity_q <= 1'b0;
      tag_x_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      f_x_valid_q <= grant;
      if (grant) begin
        f_x_data_q   <= data_arr[win_idx];
        f_x_parity_q <= req_parity[win_idx];
        tag_x_q      <= win_idx;
      end
    end
  end

  // Tag pipeline: stage 0 in the low bits, tail in the high bits.
  assign tp_d = (tp_q << SW) | TPW'({f_x_valid_q, tag_x_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tp_q <= '0;
    else       tp_q <= tp_d;
  end

  for (genvar g = 0; g < LAT; g++) begin : g_stage_v
    assign stage_v[g] = tp_q[g*SW + IW];
  end

  assign tail_v   = tp_q[TPW-1];
  assign tail_tag = tp_q[TPW-2 -: IW];

  // Response register and sticky error on valid disagreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_parity_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (f_y_valid && tail_v) begin
        rsp_valid_q  <= N'(1) << tail_tag;
        rsp_data_q   <= f_y_data;
        rsp_parity_q <= f_y_parity;
      end else begin
        rsp_valid_q <= '0;
      end
      if (f_y_valid != tail_v) err_q <= 1'b1;
    end
  end

  assign f_x_valid  = f_x_valid_q;
  assign f_x_data   = f_x_data_q;
  assign f_x_parity = f_x_parity_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_parity = rsp_parity_q;
  assign err        = err_q;
  assign busy       = f_x_valid_q | (|stage_v);

endmodule

// File: tb/tb_filter_arbiter.sv
// tb_filter_arbiter: randomized and directed stimulus against a
// transaction-level reference (grant records with issue times).
module tb_filter_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [W-1:0]  dat [N];
  logic [N-1:0]  par = '0;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [W-1:0]  f_x_data;
  logic          f_x_valid, f_x_parity;
  logic [W-1:0]  f_y_data;
  logic          f_y_valid, f_y_parity;
  logic [N-1:0]  rsp_valid;
  logic [W-1:0]  rsp_data;
  logic          rsp_parity;
  logic          busy, err;

  int checks = 0;
  int failures = 0;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  filter_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_parity(par),
    .req_ready(req_ready),
    .f_x_data(f_x_data), .f_x_valid(f_x_valid), .f_x_parity(f_x_parity),
    .f_y_data(f_y_data), .f_y_valid(f_y_valid), .f_y_parity(f_y_parity),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_parity(rsp_parity),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Filter stand-in: y = 4*x, parity passthrough, two-cycle latency.
  logic [1:0]   fp_v;
  logic [W-1:0] fp_d [2];
  logic [1:0]   fp_p;
  logic         inj = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fp_v <= '0; fp_p <= '0; fp_d[0] <= '0; fp_d[1] <= '0;
    end else begin
      fp_v[0] <= f_x_valid;  fp_d[0] <= f_x_data << 2; fp_p[0] <= f_x_parity;
      fp_v[1] <= fp_v[0];    fp_d[1] <= fp_d[0];       fp_p[1] <= fp_p[0];
    end
  end
  assign f_y_valid  = fp_v[1] | inj;
  assign f_y_data   = fp_d[1];
  assign f_y_parity = fp_p[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: every accepted sample is a record stamped with its grant edge k.
  // It is on f_x in cycle k, keeps busy high through k+LAT, responds in k+LAT+1.
  typedef struct { int k; int idx; logic [W-1:0] d; logic p; } rec_t;
  rec_t q[$];
  int          cyc = 0;
  int          ptr_m = N - 1;
  logic        err_m = 1'b0;
  logic [W-1:0] fx_d_m = '0, rsp_d_m = '0;
  logic        fx_p_m = 1'b0, rsp_p_m = 1'b0;
  logic [N-1:0] hs_mask = '0;
  int          rsp_cnt [N];
  logic        exp_fxv, exp_busy, tailv;
  logic [N-1:0] exp_rv, exp_rdy;
  int          c_m;

  initial for (int i = 0; i < N; i++) begin rsp_cnt[i] = 0; dat[i] = '0; end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      ptr_m = N - 1; err_m = 1'b0; hs_mask = '0;
      fx_d_m = '0; fx_p_m = 1'b0; rsp_d_m = '0; rsp_p_m = 1'b0;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_fxv", 32'(f_x_valid), 0);
      chk("rst_fxd", 32'(f_x_data), 0);
      chk("rst_fxp", 32'(f_x_parity), 0);
      chk("rst_rspv", 32'(rsp_valid), 0);
      chk("rst_rspd", 32'(rsp_data), 0);
      chk("rst_rspp", 32'(rsp_parity), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
    end else begin
      exp_fxv = 1'b0; exp_busy = 1'b0; exp_rv = '0; tailv = 1'b0;
      foreach (q[j]) begin
        if (q[j].k == cyc) begin
          exp_fxv = 1'b1; fx_d_m = q[j].d; fx_p_m = q[j].p;
        end
        if (q[j].k + LAT + 1 == cyc) begin
          exp_rv = N'(1) << q[j].idx; rsp_d_m = q[j].d << 2; rsp_p_m = q[j].p;
        end
        if (cyc >= q[j].k && cyc <= q[j].k + LAT) exp_busy = 1'b1;
        if (q[j].k + LAT == cyc) tailv = 1'b1;
      end
      chk("fx_valid", 32'(f_x_valid), 32'(exp_fxv));
      chk("fx_data", 32'(f_x_data), 32'(fx_d_m));
      chk("fx_parity", 32'(f_x_parity), 32'(fx_p_m));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("rsp_data", 32'(rsp_data), 32'(rsp_d_m));
      chk("rsp_parity", 32'(rsp_parity), 32'(rsp_p_m));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("err", 32'(err), 32'(err_m));
      for (int i = 0; i < N; i++) if (rsp_valid[i]) rsp_cnt[i]++;
      if (inj && !tailv) err_m = 1'b1;
      while (q.size() > 0 && q[0].k + LAT + 1 <= cyc) void'(q.pop_front());

      exp_rdy = '0;
      if (enable)
        for (int off = 1; off <= N; off++) begin
          c_m = (ptr_m + off) % N;
          if (exp_rdy == '0 && req_valid[c_m]) exp_rdy[c_m] = 1'b1;
        end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      hs_mask = exp_rdy;
      for (int i = 0; i < N; i++)
        if (exp_rdy[i]) begin
          q.push_back('{k: cyc + 1, idx: i, d: dat[i], p: par[i]});
          ptr_m = i;
        end
    end
  end

  logic hold = 1'b0;
  int   base0, base2;

  task automatic step();
    @(posedge clk);
    #1;
    if (hold) req_valid = req_valid & ~hs_mask;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic randomize_inputs();
    req_valid = N'($urandom);
    par = N'($urandom);
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
  endtask

  initial begin
    // Reset held two cycles with every requester pending.
    #1 reset = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) dat[i] = W'(16'h10 + i);
    steps(2);
    reset = 1'b0;
    req_valid = '0;
    chk("first_grant", 32'(req_ready), 0);
    req_valid = 4'b1110;           // with 0 absent, 1 must win after reset
    #1 chk("grant_after_rst", 32'(req_ready), 32'(4'b0010));
    req_valid = 4'b1111;
    #1 chk("grant0_after_rst", 32'(req_ready), 32'(4'b0001));
    req_valid = '0;
    steps(6);

    // Single sample from requester 0.
    hold = 1'b1;
    dat[0] = 16'd3; par = 4'b0000; req_valid = 4'b0001;
    steps(6);

    // All four pending, data 1..4, held until granted.
    for (int i = 0; i < N; i++) dat[i] = W'(i + 1);
    par = 4'b1010; req_valid = 4'b1111;
    steps(8);

    // Requesters 0 and 2 continuously valid for eight grants.
    hold = 1'b0;
    base0 = rsp_cnt[0]; base2 = rsp_cnt[2];
    req_valid = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      dat[0] = W'($urandom); dat[2] = W'($urandom); par = N'($urandom);
      step();
    end
    req_valid = '0;
    steps(5);
    chk("cnt_req0", 32'(rsp_cnt[0] - base0), 4);
    chk("cnt_req2", 32'(rsp_cnt[2] - base2), 4);

    // Enable drop with requests pending and two samples in flight.
    hold = 1'b1;
    randomize_inputs();
    req_valid = 4'b1111;
    steps(2);
    enable = 1'b0;
    steps(6);
    chk("busy_drain", 32'(busy), 0);
    chk("err_drain", 32'(err), 0);
    chk("ready_disabled", 32'(req_ready), 0);
    enable = 1'b1;
    steps(8);

    // Randomized traffic.
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      enable = ($urandom_range(0, 7) != 0);
      step();
    end
    req_valid = '0; enable = 1'b1;
    steps(5);

    // Spurious filter valid with an empty tag pipeline.
    inj = 1'b1;
    step();
    inj = 1'b0;
    step();
    chk("err_set", 32'(err), 1);
    chk("err_no_rsp", 32'(rsp_valid), 0);
    for (int n = 0; n < 20; n++) begin randomize_inputs(); step(); end
    chk("err_sticky", 32'(err), 1);
    reset = 1'b1;
    #1 chk("err_clr", 32'(err), 0);
    steps(2);
    reset = 1'b0;
    req_valid = '0;
    steps(3);

    // Reset in the middle of traffic discards in-flight samples.
    for (int n = 0; n < 10; n++) begin randomize_inputs(); step(); end
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    req_valid = '0;
    steps(6);

    // Final random burst after reset.
    for (int n = 0; n < 100; n++) begin randomize_inputs(); step(); end
    req_valid = '0;
    steps(6);
    chk("final_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/filter_arbiter.md
FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter W, default 16, meaning sample data width.
REQ-003 SHALL have parameter LAT, default 2, meaning filter datapath latency in cycles (valid in to valid out).
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  grant enable; low means no new grants.
REQ-007 SHALL have port req_valid  in  N  per-requester sample valid.
REQ-008 SHALL have port req_data  in  N*W  per-requester sample; requester i occupies bits [i*W+W-1 : i*W].
REQ-009 SHALL have port req_parity  in  N  per-requester parity bit, passed through unchanged.
REQ-010 SHALL have port req_ready  out  N  one-hot (or zero) grant; handshake = req_valid[i] & req_ready[i] at clk edge.
REQ-011 SHALL have port f_x_data  out  W, f_x_valid  out  1, f_x_parity  out  1  registered drive to filter input.
REQ-012 SHALL have port f_y_data  in  W, f_y_valid  in  1, f_y_parity  in  1  filter output.
REQ-013 SHALL have port rsp_valid  out  N  one-hot response strobe to owning requester.
REQ-014 SHALL have port rsp_data  out  W, rsp_parity  out  1  registered response payload.
REQ-015 SHALL have port busy  out  1  high while any sample is in flight (in f_x stage or tag pipeline).
REQ-016 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-017 SHALL arbitrate round-robin: search starts at requester (last_grant+1) mod N; lowest index after pointer with req_valid wins.
REQ-018 SHALL drive req_ready combinationally from req_valid, enable and pointer; at most one bit set; zero when enable=0 or no req_valid.
REQ-019 SHALL advance pointer to the granted index only on a completed handshake; no handshake leaves pointer unchanged.
REQ-020 SHALL on handshake at edge k register f_x_data/f_x_parity from the winner and f_x_valid=1 for the cycle after k; f_x_valid=0 and f_x_data/f_x_parity hold otherwise.
REQ-021 SHALL carry a {valid, tag[log2 N]} shift pipeline of LAT stages alongside the filter, loaded with the winner index at the f_x stage.
REQ-022 SHALL at edge k+LAT+1 set rsp_valid bit tag (one-hot), rsp_data=f_y_data, rsp_parity=f_y_parity when f_y_valid and tag-pipeline tail valid are both 1; rsp_valid=0 otherwise, payload held.
REQ-023 SHALL sustain one grant per cycle; back-to-back responses SHALL emerge in grant order with no gaps.
REQ-024 SHALL set err on any cycle where f_y_valid differs from tag-pipeline tail valid; response suppressed that cycle; err stays 1 until reset.
REQ-025 SHALL compute busy as OR of f_x_valid and all tag-pipeline valid bits.
REQ-026 SHALL apply no backpressure to the filter or responses (no stall path); requesters SHALL accept rsp_valid unconditionally.
REQ-027 SHALL on enable falling keep draining in-flight samples; busy falls LAT+1 cycles after last grant.

Reset
REQ-028 SHALL on reset assertion asynchronously clear: pointer to N-1 (requester 0 first), f_x_valid/f_x_data/f_x_parity, tag pipeline, rsp_valid/rsp_data/rsp_parity, err, busy to 0.
REQ-029 SHALL drive req_ready=0 while reset is high; reset mid-operation SHALL discard in-flight samples with no response issued.

Verification (bench filter model: y = 4*x, parity passthrough, LAT=2)
REQ-030 Reset held 2 cycles, requests pending -> all outputs 0, req_ready=0; first grant after release is requester 0.
REQ-031 req_valid=0001, req_data[0]=3, parity 0 at edge k -> f_x_valid=1 after k; rsp_valid=0001, rsp_data=12, rsp_parity=0 after edge k+3; busy high cycles k..k+2.
REQ-032 All four valid with data 1,2,3,4 held until granted -> grants 0,1,2,3 on consecutive edges; rsp_valid 0001,0010,0100,1000 back-to-back, rsp_data 4,8,12,16.
REQ-033 req_valid=0101 held 8 cycles -> grants alternate 0,2,0,2...; each requester receives 4 responses.
REQ-034 enable dropped with requests pending and 2 in flight -> req_ready=0; both responses delivered; busy 0 after drain; err stays 0.
REQ-035 Force f_y_valid=1 with empty tag pipeline -> err=1, rsp_valid=0; err remains 1 until reset asserted, then 0.
